// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned pulse/level outputs
// between the button pads and the duty-level counter.
interface button_conditioner_if;
    logic       incr_raw_i;
    logic       decr_raw_i;
    logic       incr_pulse_o;
    logic       decr_pulse_o;
    logic [1:0] btn_level_o;

    modport master (
        output incr_raw_i,
        output decr_raw_i,
        input  incr_pulse_o,
        input  decr_pulse_o,
        input  btn_level_o
    );

    modport slave (
        input  incr_raw_i,
        input  decr_raw_i,
        output incr_pulse_o,
        output decr_pulse_o,
        output btn_level_o
    );
endinterface

// File: rtl/button_conditioner.sv
// Two-channel button conditioner: synchroniser, debounce,
// press pulse, hold-to-repeat and two-button lockout.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned REPEAT_DLY   = 5000000,
    parameter int unsigned REPEAT_PER   = 1000000,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    button_conditioner_if.slave btn
);

    localparam int unsigned TMR_MAX =
        (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TMR_MAX + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PER - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    // Bit 0 is the increase channel, bit 1 the decrease channel.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    lvl_q;
    logic [1:0]    lvl_d;
    logic [1:0]    lvl_out_q;
    logic [1:0]    oth;
    logic [1:0]    pulse_q;
    logic [1:0]    pulse_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];
    logic [TW-1:0] tmr_q [2];
    logic [TW-1:0] tmr_d [2];
    state_t        st_q  [2];
    state_t        st_d  [2];

    assign raw = {btn.decr_raw_i, btn.incr_raw_i};
    assign oth = {lvl_q[0], lvl_q[1]};

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                lvl_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // IDLE with the level high can only mean a fresh rise:
    // every path back to IDLE requires the level to be low.
    always_comb begin
        st_d    = st_q;
        tmr_d   = tmr_q;
        pulse_d = '0;
        for (int i = 0; i < 2; i++) begin
            unique case (st_q[i])
                IDLE: begin
                    if (lvl_q[i]) begin
                        if (oth[i]) begin
                            st_d[i] = LOCK;
                        end else begin
                            pulse_d[i] = 1'b1;
                            tmr_d[i]   = '0;
                            st_d[i]    = HOLD;
                        end
                    end
                end
                HOLD, REPEAT: begin
                    if (!lvl_q[i]) begin
                        st_d[i] = IDLE;
                    end else if (oth[i]) begin
                        st_d[i] = LOCK;
                    end else if (REPEAT_EN) begin
                        if (tmr_q[i] == ((st_q[i] == HOLD) ?
                                         DLY_LAST : PER_LAST)) begin
                            pulse_d[i] = 1'b1;
                            tmr_d[i]   = '0;
                            st_d[i]    = REPEAT;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (!lvl_q[i]) begin
                        st_d[i] = IDLE;
                    end
                end
                default: st_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            lvl_out_q <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
                tmr_q[i] <= '0;
                st_q[i]  <= IDLE;
            end
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            lvl_out_q <= lvl_q;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            st_q      <= st_d;
        end
    end

    assign btn.incr_pulse_o = pulse_q[0];
    assign btn.decr_pulse_o = pulse_q[1];
    assign btn.btn_level_o  = lvl_out_q;

endmodule
